distance_accum: RTL
===================

// Module: distance_accum
// PURPOSE
// - Streaming distance engine feeding the distance PIO's 32-bit in_port; the CPU samples dist_out via that PIO.
// - Per start: consumes N_PIX pixel pairs (image vs template), accumulates SAD or SSD, holds result stable.
// - Sits between the pixel/template memory reader (upstream) and the distance PIO (downstream).
// PARAMETERS
// - PIX_W     8    pixel width, unsigned
// - N_PIX     784  pixel pairs per comparison (>=1)
// - DIST_MODE 0    0 = sum |a-b| (SAD), 1 = sum (a-b)^2 (SSD)
// PORTS
// - clk        in   1      clock, all logic on rising edge
// - reset_n    in   1      reset, asynchronous, active-low
// - start      in   1      begin new comparison; honoured only in IDLE or DONE
// - pix_valid  in   1      pix_a/pix_b valid this cycle
// - pix_a      in   PIX_W  image pixel
// - pix_b      in   PIX_W  template pixel
// - pix_ready  out  1      block accepts a pair; beat = pix_valid & pix_ready
// - busy       out  1      high from start acceptance until dist_valid
// - dist_valid out  1      one-cycle pulse: new result on dist_out
// - dist_out   out  32     last completed distance, held until next completion
// - overflow   out  1      sticky per comparison: accumulator saturated
// BEHAVIOUR
// - Reset: state IDLE; pix_ready, busy, dist_valid, overflow = 0; dist_out = 0; counter, pipe, acc cleared.
// - States: IDLE -> ACCUM (start) -> DRAIN (N_PIX-th beat accepted) -> DONE (pipe empty) -> ACCUM (start).
// - IDLE/DONE: pix_ready=0, busy=0; start clears acc, beat counter, overflow; next cycle ACCUM.
// - ACCUM: pix_ready=1, busy=1; pix_valid low = stall, no count. Counter width $clog2(N_PIX+1).
// - pix_ready deasserts combinationally in the cycle after the N_PIX-th beat; no extra beat accepted.
// - Pipe stage 1 (reg): diff=|a-b| (PIX_W bits); term = diff (SAD) or diff*diff (2*PIX_W bits, SSD).
// - Pipe stage 2 (reg): acc = acc + term, zero-extended to 33 bits; if bit32 set, acc=32'hFFFF_FFFF, overflow=1.
// - Saturation holds: once saturated, acc stays 32'hFFFF_FFFF for rest of comparison.
// - DRAIN: pix_ready=0, busy=1; waits for the two pipe stages to empty.
// - Latency: last beat accepted at edge E -> term at E+1, acc at E+2, dist_out/dist_valid at E+3.
// - dist_valid high exactly one cycle (E+3 to E+4); dist_out updates only then, stable otherwise.
// - start during ACCUM/DRAIN ignored (no restart, no abort). start in the dist_valid cycle honoured.
// - overflow valid with dist_valid, holds until next accepted start.
// - reset_n low mid-comparison: immediate abort, all outputs to reset values, partial result discarded.
// - pix_a==pix_b -> term 0; all-equal images -> dist_out 0, overflow 0.
// STRUCTURE
// - Package dist_pkg: DIST_SAD=0 / DIST_SSD=1 constants, state enum {IDLE,ACCUM,DRAIN,DONE}, DIST_W=32.
// - Sub-module abs_diff_term (PIX_W, DIST_MODE): combinational |a-b| and optional square; top registers it.
// - Top: FSM, beat counter, stage-1/2 pipeline registers, saturating accumulator, dist_out register.
// TESTING
// - N_PIX=4, SAD, pairs (10,3),(3,10),(0,255),(7,7) back-to-back -> dist_out=269, dist_valid 3 cycles after last beat.
// - N_PIX=4, SSD, same pairs -> dist_out=65123; overflow=0; pix_ready low after 4th beat.
// - pix_valid toggled 1-0-0-1-0-1-1 -> only 4 accepted beats counted; result identical to back-to-back run.
// - N_PIX=784, SSD, PIX_W=16, all (65535,0) -> saturates: dist_out=32'hFFFF_FFFF, overflow=1.
// - start pulsed mid-ACCUM -> ignored, result unchanged; start in dist_valid cycle -> new run, old dist_out held till next pulse.
// - reset_n low after 2 beats -> outputs zero immediately; new start yields full correct distance.

Source files
------------

// File: rtl/dist_pkg.sv
// Shared constants and state encoding for the streaming distance engine.
package dist_pkg;
    localparam int DIST_SAD = 0;
    localparam int DIST_SSD = 1;
    localparam int DIST_W   = 32;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
endpackage

// File: rtl/abs_diff_term.sv
// Combinational per-pair term: |a-b| for SAD, |a-b|^2 for SSD.
module abs_diff_term
    import dist_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int DIST_MODE = DIST_SAD
) (
    input  logic [PIX_W-1:0]   a,
    input  logic [PIX_W-1:0]   b,
    output logic [2*PIX_W-1:0] term
);
    logic [PIX_W-1:0]   diff;
    logic [2*PIX_W-1:0] diff_ext;

    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
    end

    assign diff_ext = {{PIX_W{1'b0}}, diff};

    generate
        if (DIST_MODE == DIST_SSD) begin : g_ssd
            assign term = diff_ext * diff_ext;
        end else begin : g_sad
            assign term = diff_ext;
        end
    endgenerate
endmodule

// File: rtl/distance_accum.sv
// Streaming SAD/SSD engine: counts N_PIX beats, two-stage term/accumulate pipe,
// saturating 32-bit accumulator, result held on dist_out between completions.
module distance_accum
    import dist_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int N_PIX     = 784,
    parameter int DIST_MODE = DIST_SAD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_a,
    input  logic [PIX_W-1:0]  pix_b,
    output logic              pix_ready,
    output logic              busy,
    output logic              dist_valid,
    output logic [DIST_W-1:0] dist_out,
    output logic              overflow
);
    localparam int CNT_W  = $clog2(N_PIX + 1);
    localparam int TERM_W = 2 * PIX_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TERM_W-1:0]  term, term_q;
    logic [1:0]         vld_pipe;
    logic [DIST_W-1:0]  acc;
    logic [DIST_W:0]    sum;
    logic               start_ok, beat, last_beat, drained;

    abs_diff_term #(.PIX_W(PIX_W), .DIST_MODE(DIST_MODE)) u_term (
        .a   (pix_a),
        .b   (pix_b),
        .term(term)
    );

    // beat is decoded from state directly so pix_ready never feeds back into the FSM comb block
    assign start_ok  = start & ((state == IDLE) | (state == DONE));
    assign beat      = pix_valid & (state == ACCUM);
    assign last_beat = beat & (cnt == CNT_W'(N_PIX - 1));
    assign drained   = (state == DRAIN) & vld_pipe[1] & ~vld_pipe[0];
    assign sum       = {1'b0, acc} + {{(DIST_W + 1 - TERM_W){1'b0}}, term_q};

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = ACCUM;
            ACCUM: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drained) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            term_q     <= '0;
            vld_pipe   <= '0;
            acc        <= '0;
            overflow   <= 1'b0;
            dist_out   <= '0;
            dist_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            vld_pipe   <= {vld_pipe[0], beat};
            dist_valid <= drained;
            if (beat) term_q <= term;
            if (start_ok) begin
                cnt      <= '0;
                acc      <= '0;
                overflow <= 1'b0;
            end else begin
                if (beat) cnt <= cnt + CNT_W'(1);
                // a carry out of bit 31 pins the sum at all-ones; later carries keep it there
                if (vld_pipe[0]) begin
                    if (sum[DIST_W]) begin
                        acc      <= '1;
                        overflow <= 1'b1;
                    end else begin
                        acc <= sum[DIST_W-1:0];
                    end
                end
            end
            if (drained) dist_out <= acc;
        end
    end
endmodule
